// File: rtl/pedestrian_xing_if.sv
// Pedestrian crossing signal bundle: request button in, lamp drives out.
// The signal names keep the original pin names of the crossing controller.
interface pedestrian_xing_if;
    logic pin10_ped_button;
    logic pin4_green;
    logic pin5_yellow;
    logic pin6_red;
    logic pin7_ped_green;
    logic pin8_ped_red;
    logic pin11_wait_lamp;

    modport master (
        output pin10_ped_button,
        input  pin4_green, pin5_yellow, pin6_red,
        input  pin7_ped_green, pin8_ped_red, pin11_wait_lamp
    );

    modport slave (
        input  pin10_ped_button,
        output pin4_green, pin5_yellow, pin6_red,
        output pin7_ped_green, pin8_ped_red, pin11_wait_lamp
    );
endinterface

// File: rtl/pedestrian_xing.sv
// Pedestrian crossing controller: road/pedestrian lamp sequencer with a
// synchronised request button, per-phase seconds timer and lamp test.
// Optional build macro PED_FLASH_EN: flashes the pedestrian green lamp
// (half-second on/off) during the pedestrian clearance phase.
module pedestrian_xing #(
    parameter int TIMER_SCALE = 16000000,
    parameter int T_LAMPTEST  = 2,
    parameter int T_MIN_GREEN = 10,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 2,
    parameter int T_PED_WALK  = 8,
    parameter int T_PED_CLEAR = 4
) (
    input logic               pin3_clk_16mhz,
    input logic               pin9_reset,
    pedestrian_xing_if.slave  xing
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int T_MAX = max2(max2(max2(T_LAMPTEST, T_MIN_GREEN), max2(T_YELLOW, T_ALLRED)),
                                max2(T_PED_WALK, T_PED_CLEAR));
    localparam int PW = $clog2(TIMER_SCALE);
    localparam int SW = $clog2(T_MAX + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TIMER_SCALE - 1);
`ifdef PED_FLASH_EN
    localparam logic [PW-1:0] HALF = PW'(TIMER_SCALE / 2);
`endif

    typedef enum logic [2:0] {
        LAMPTEST   = 3'd0,
        ROADGREEN  = 3'd1,
        ROADYELLOW = 3'd2,
        ALLRED     = 3'd3,
        PEDWALK    = 3'd4,
        PEDCLEAR   = 3'd5,
        PEDALLRED  = 3'd6
    } state_t;

    state_t          state_q;
    state_t          state_nxt;
    logic            leave;
    logic [1:0]      sync_q;
    logic            btn_prev_q;
    logic            btn_rise;
    logic            req_q;
    logic            min_green_q;
    logic            armed_q;
    logic [PW-1:0]   pre_q;
    logic [PW-1:0]   pre_nxt;
    logic [SW-1:0]   sec_q;
    logic [SW-1:0]   sec_last;
    logic            phase_done;
    logic [4:0]      lamps_q;   // {ped_red, ped_green, red, yellow, green}

    // Lamp pattern for each state; illegal encodings show the lamp test pattern.
    function automatic logic [4:0] lamp_pattern(input state_t s);
        case (s)
            LAMPTEST:   return 5'b11111;
            ROADGREEN:  return 5'b10001;
            ROADYELLOW: return 5'b10010;
            ALLRED:     return 5'b10100;
            PEDWALK:    return 5'b01100;
            PEDCLEAR:   return 5'b01100;
            PEDALLRED:  return 5'b10100;
            default:    return 5'b11111;
        endcase
    endfunction

    assign btn_rise   = sync_q[1] & ~btn_prev_q;
    assign pre_nxt    = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    assign phase_done = (pre_q == PRE_LAST) && (sec_q == sec_last);

    // Phase length selection and next-state decision.
    always_comb begin
        state_nxt = state_q;
        leave     = 1'b0;
        sec_last  = '0;
        case (state_q)
            LAMPTEST: begin
                sec_last = SW'(T_LAMPTEST - 1);
                if (phase_done) begin state_nxt = ROADGREEN; leave = 1'b1; end
            end
            ROADGREEN: begin
                sec_last = SW'(T_MIN_GREEN - 1);
                if ((phase_done || min_green_q) && req_q) begin state_nxt = ROADYELLOW; leave = 1'b1; end
            end
            ROADYELLOW: begin
                sec_last = SW'(T_YELLOW - 1);
                if (phase_done) begin state_nxt = ALLRED; leave = 1'b1; end
            end
            ALLRED: begin
                sec_last = SW'(T_ALLRED - 1);
                if (phase_done) begin state_nxt = PEDWALK; leave = 1'b1; end
            end
            PEDWALK: begin
                sec_last = SW'(T_PED_WALK - 1);
                if (phase_done) begin state_nxt = PEDCLEAR; leave = 1'b1; end
            end
            PEDCLEAR: begin
                sec_last = SW'(T_PED_CLEAR - 1);
                if (phase_done) begin state_nxt = PEDALLRED; leave = 1'b1; end
            end
            PEDALLRED: begin
                sec_last = SW'(T_ALLRED - 1);
                if (phase_done) begin state_nxt = ROADGREEN; leave = 1'b1; end
            end
            default: begin
                state_nxt = LAMPTEST;
                leave     = 1'b1;
            end
        endcase
    end

    // State, timers, request flag, button synchroniser and registered lamps.
    always_ff @(posedge pin3_clk_16mhz) begin
        if (pin9_reset) begin
            sync_q      <= '0;
            btn_prev_q  <= 1'b0;
            req_q       <= 1'b0;
            min_green_q <= 1'b0;
            armed_q     <= 1'b0;
            pre_q       <= '0;
            sec_q       <= '0;
            state_q     <= LAMPTEST;
            lamps_q     <= '0;
        end else begin
            sync_q     <= {sync_q[0], xing.pin10_ped_button};
            btn_prev_q <= sync_q[1];
            if (!armed_q) begin
                // The first edge out of reset acts as the LAMPTEST entry edge:
                // counters stay at their reload value so the phase runs full length.
                armed_q <= 1'b1;
                lamps_q <= lamp_pattern(LAMPTEST);
                if (btn_rise) req_q <= 1'b1;
            end else begin
                state_q <= state_nxt;
                lamps_q <= lamp_pattern(state_nxt);
`ifdef PED_FLASH_EN
                if (state_nxt == PEDCLEAR) lamps_q[3] <= leave | (pre_nxt < HALF);
`endif
                if (leave) begin
                    pre_q       <= '0;
                    sec_q       <= '0;
                    min_green_q <= 1'b0;
                end else if (!(state_q == ROADGREEN && min_green_q)) begin
                    // Road green freezes its timer once minimum green has elapsed.
                    pre_q <= pre_nxt;
                    if (pre_q == PRE_LAST) sec_q <= sec_q + SW'(1);
                    if (state_q == ROADGREEN && phase_done) min_green_q <= 1'b1;
                end
                if (leave && state_nxt == PEDWALK) req_q <= 1'b0;
                else if (btn_rise && state_q != PEDWALK) req_q <= 1'b1;
            end
        end
    end

    assign xing.pin4_green      = lamps_q[0];
    assign xing.pin5_yellow     = lamps_q[1];
    assign xing.pin6_red        = lamps_q[2];
    assign xing.pin7_ped_green  = lamps_q[3];
    assign xing.pin8_ped_red    = lamps_q[4];
    assign xing.pin11_wait_lamp = req_q | (armed_q & (state_q == LAMPTEST));

endmodule
